servo_btn_ctrl: RTL and testbench
=================================

SERVO_BTN_CTRL -- requirements
Module: servo_btn_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000: clk frequency in Hz.
REQ-002 Parameter STEP_US, default 10: pulse-width change per step, in microseconds.
REQ-003 Parameter HOLD_MS, default 500: continuous hold time before auto-repeat starts.
REQ-004 Parameter RPT_MS, default 100: auto-repeat step interval.
REQ-005 Parameters PW_MIN / PW_MID / PW_MAX, defaults 500 / 1500 / 2500: pulse-width limits and centre, in microseconds.
REQ-006 Port clk, input, 1: system clock, 12 MHz, single clock domain.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port btn_deb, input, 3: debounced buttons, active-high pressed; [0] inc, [1] dec, [2] centre.
REQ-009 Port pulse_us, output, 12: commanded servo pulse width in microseconds, consumed by the PWM generator.
REQ-010 Port step_stb, output, 1: single-cycle strobe asserted in the cycle pulse_us takes a new value.
REQ-011 Ports at_min and at_max, outputs, 1 each: combinational flags, pulse_us==PW_MIN and pulse_us==PW_MAX respectively.

Function
REQ-012 The block SHALL register btn_deb into btn_prev every cycle and detect a rising edge per bit as btn_deb & ~btn_prev.
REQ-013 The FSM SHALL have three states: IDLE, HOLD and REPEAT.
REQ-014 In IDLE, a centre rising edge SHALL load PW_MID into pulse_us in the next cycle and pulse step_stb; the FSM stays in IDLE.
REQ-015 In IDLE, an inc or dec rising edge with the other direction button released SHALL apply one step in the next cycle, clear the ms counters and enter HOLD.
REQ-016 In HOLD, the block SHALL count ms ticks (CLK_FREQ/1000 cycles each, counter restarted on HOLD entry); after HOLD_MS ticks of continuous hold it SHALL apply one step and enter REPEAT.
REQ-017 In REPEAT, the block SHALL apply one step every RPT_MS ms ticks while the same direction button stays pressed.
REQ-018 In HOLD or REPEAT, release of the active button, a press of the opposite button, or a press of centre SHALL return the FSM to IDLE with no step in that cycle.
REQ-019 Centre SHALL have priority: a centre edge coincident with an inc or dec edge SHALL only centre the output.
REQ-020 Simultaneous inc and dec rising edges SHALL be ignored, with no step and no state change.
REQ-021 A step SHALL saturate: inc gives min(pulse_us+STEP_US, PW_MAX); dec gives max(pulse_us-STEP_US, PW_MIN).
REQ-022 Arithmetic SHALL be at least 13 bits wide so the result never wraps.
REQ-023 step_stb SHALL assert only when pulse_us actually changes; a step at a limit produces no strobe but keeps the FSM timing unchanged.
REQ-024 Latency SHALL be exactly one cycle from the qualifying btn_deb edge to the updated pulse_us.

Reset
REQ-025 When rst is high at a clk edge, the block SHALL set pulse_us=PW_MID, step_stb=0, state=IDLE, btn_prev=3'b000, and all counters to 0.
REQ-026 Reset SHALL take precedence over any button activity; a button already held when rst falls SHALL produce a step at the first cycle after reset.

Configuration
REQ-027 The macro SERVO_BTN_REPEAT_EN SHALL select auto-repeat.
REQ-028 With SERVO_BTN_REPEAT_EN defined, the block SHALL behave as REQ-016 and REQ-017.
REQ-029 Without SERVO_BTN_REPEAT_EN, the HOLD and REPEAT states and the ms counters SHALL be absent; each inc/dec edge gives exactly one step and the FSM stays in IDLE.

Verification
The bench runs with CLK_FREQ=12000 (12 cycles/ms), HOLD_MS=5, RPT_MS=2, and SERVO_BTN_REPEAT_EN defined unless noted.
REQ-030 Release rst; pulse inc for 3 cycles -> pulse_us goes 1500 to 1510 one cycle after the edge, with step_stb high for 1 cycle.
REQ-031 Hold inc for 200 cycles -> steps at cycle +1, +61, then every 24 cycles; pulse_us reads 1510, 1520, then 1530, 1540, ... .
REQ-032 Preload pulse_us to 2500 via repeated inc; press inc again -> pulse_us stays 2500, step_stb stays 0, at_max=1.
REQ-033 Press inc and dec in the same cycle -> no change and no strobe; then press centre together with dec -> pulse_us=1500.
REQ-034 Assert rst while in REPEAT at pulse_us=1700 -> next cycle pulse_us=1500, state IDLE, step_stb=0.
REQ-035 Without SERVO_BTN_REPEAT_EN, hold dec for 200 cycles -> exactly one step, 1500 to 1490.

Source files
------------

// File: rtl/servo_btn_ctrl.sv
// servo_btn_ctrl: button-driven servo pulse-width controller.
// Debounced inc/dec/centre buttons adjust a pulse width in microseconds
// with saturation at PW_MIN/PW_MAX. Optional press-and-hold auto-repeat
// is compiled in when the macro SERVO_BTN_REPEAT_EN is defined; without it
// every inc/dec edge yields exactly one step and no ms timing exists.
// fsm_state exposes the controller state (0=IDLE, 1=HOLD, 2=REPEAT).
module servo_btn_ctrl #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int STEP_US  = 10,
    parameter int HOLD_MS  = 500,
    parameter int RPT_MS   = 100,
    parameter int PW_MIN   = 500,
    parameter int PW_MID   = 1500,
    parameter int PW_MAX   = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  btn_deb,
    output logic [11:0] pulse_us,
    output logic        step_stb,
    output logic        at_min,
    output logic        at_max,
    output logic [1:0]  fsm_state
);

    localparam logic [12:0] STEP13 = 13'(STEP_US);
    localparam logic [12:0] MIN13  = 13'(PW_MIN);
    localparam logic [12:0] MAX13  = 13'(PW_MAX);
    localparam logic [11:0] MID12  = 12'(PW_MID);

    logic [2:0]  btn_prev;
    logic [2:0]  rise;
    logic [11:0] pulse_nxt;

    assign rise   = btn_deb & ~btn_prev;
    assign at_min = (pulse_us == 12'(PW_MIN));
    assign at_max = (pulse_us == 12'(PW_MAX));

    // One saturating step; 13-bit math so neither direction can wrap.
    function automatic logic [11:0] step_value(input logic [11:0] cur, input logic dec);
        logic [12:0] cur13;
        logic [12:0] res;
        cur13 = {1'b0, cur};
        if (dec) begin
            if (cur13 < MIN13 + STEP13) res = MIN13;
            else                        res = cur13 - STEP13;
        end else begin
            if (cur13 + STEP13 > MAX13) res = MAX13;
            else                        res = cur13 + STEP13;
        end
        return res[11:0];
    endfunction

`ifdef SERVO_BTN_REPEAT_EN
    localparam int CYC_PER_MS = (CLK_FREQ / 1000 < 2) ? 2 : CLK_FREQ / 1000;
    localparam int CYC_W      = $clog2(CYC_PER_MS);
    localparam int MS_MAX     = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
    localparam int MS_W       = (MS_MAX < 2) ? 1 : $clog2(MS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             dir, dir_nxt;        // 0 = inc active, 1 = dec active
    logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
    logic [MS_W-1:0]  ms_cnt, ms_nxt;
    logic             tick;
    logic             active_btn;
    logic             other_btn;
    logic [MS_W-1:0]  ms_limit;

    assign tick       = (cyc_cnt == CYC_W'(CYC_PER_MS - 1));
    assign active_btn = dir ? btn_deb[1] : btn_deb[0];
    assign other_btn  = dir ? btn_deb[0] : btn_deb[1];
    assign ms_limit   = (state == HOLD) ? MS_W'(HOLD_MS - 1) : MS_W'(RPT_MS - 1);
    assign fsm_state  = state;

    // Next-state, ms timing and next pulse width.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cyc_nxt   = cyc_cnt;
        ms_nxt    = ms_cnt;
        pulse_nxt = pulse_us;
        case (state)
            IDLE: begin
                if (rise[2]) begin
                    pulse_nxt = MID12;
                end else if (rise[0] && !btn_deb[1]) begin
                    pulse_nxt = step_value(pulse_us, 1'b0);
                    dir_nxt   = 1'b0;
                    cyc_nxt   = '0;
                    ms_nxt    = '0;
                    state_nxt = HOLD;
                end else if (rise[1] && !btn_deb[0]) begin
                    pulse_nxt = step_value(pulse_us, 1'b1);
                    dir_nxt   = 1'b1;
                    cyc_nxt   = '0;
                    ms_nxt    = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (btn_deb[2] || !active_btn || other_btn) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                    ms_nxt    = '0;
                end else begin
                    cyc_nxt = tick ? '0 : cyc_cnt + 1'b1;
                    if (tick) begin
                        if (ms_cnt == ms_limit) begin
                            pulse_nxt = step_value(pulse_us, dir);
                            ms_nxt    = '0;
                            state_nxt = REPEAT;
                        end else begin
                            ms_nxt = ms_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, active direction and ms counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= 1'b0;
            cyc_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            dir     <= dir_nxt;
            cyc_cnt <= cyc_nxt;
            ms_cnt  <= ms_nxt;
        end
    end
`else
    assign fsm_state = 2'd0;

    // Edge-only stepping: centre wins, simultaneous inc+dec is ignored.
    always_comb begin
        pulse_nxt = pulse_us;
        if (rise[2])                      pulse_nxt = MID12;
        else if (rise[0] && !btn_deb[1])  pulse_nxt = step_value(pulse_us, 1'b0);
        else if (rise[1] && !btn_deb[0])  pulse_nxt = step_value(pulse_us, 1'b1);
    end
`endif

    // Button history, pulse width register and change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 3'b000;
            pulse_us <= MID12;
            step_stb <= 1'b0;
        end else begin
            btn_prev <= btn_deb;
            pulse_us <= pulse_nxt;
            step_stb <= (pulse_nxt != pulse_us);
        end
    end

endmodule

// File: tb/tb_servo_btn_ctrl.sv
// Directed bench for servo_btn_ctrl at 12 cycles/ms, HOLD_MS=5, RPT_MS=2.
// Repeat-timing checks run when SERVO_BTN_REPEAT_EN is defined; otherwise
// the single-step-per-edge behaviour is checked.
module tb_servo_btn_ctrl;

    localparam int ST_IDLE   = 0;
    localparam int ST_HOLD   = 1;
    localparam int ST_REPEAT = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  btn_deb;
    logic [11:0] pulse_us;
    logic        step_stb;
    logic        at_min;
    logic        at_max;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    servo_btn_ctrl #(
        .CLK_FREQ(12000),
        .STEP_US (10),
        .HOLD_MS (5),
        .RPT_MS  (2),
        .PW_MIN  (500),
        .PW_MID  (1500),
        .PW_MAX  (2500)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_deb  (btn_deb),
        .pulse_us (pulse_us),
        .step_stb (step_stb),
        .at_min   (at_min),
        .at_max   (at_max),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // press a button for one cycle, then release for one cycle
    task automatic tap(input logic [2:0] b);
        btn_deb = b;
        tick();
        btn_deb = 3'b000;
        tick();
    endtask

    initial begin
        int stb_cnt;
        int found;
        int exp_cyc[7] = '{1, 61, 85, 109, 133, 157, 181};

        rst = 1'b1;
        btn_deb = 3'b000;
        repeat (3) tick();
        check("reset_pulse", pulse_us, 1500);
        check("reset_stb", step_stb, 0);
        check("reset_state", fsm_state, ST_IDLE);
        check("reset_flags", {at_min, at_max}, 0);
        rst = 1'b0;
        tick();

        // single inc press held 3 cycles
        btn_deb = 3'b001;
        tick();
        check("inc_pulse", pulse_us, 1510);
        check("inc_stb", step_stb, 1);
`ifdef SERVO_BTN_REPEAT_EN
        check("inc_state_hold", fsm_state, ST_HOLD);
`endif
        tick();
        check("inc_stb_drop", step_stb, 0);
        tick();
        btn_deb = 3'b000;
        tick();
        check("inc_release_pulse", pulse_us, 1510);
        check("inc_release_state", fsm_state, ST_IDLE);

        // simultaneous inc+dec ignored
        btn_deb = 3'b011;
        tick();
        check("incdec_pulse", pulse_us, 1510);
        check("incdec_stb", step_stb, 0);
        check("incdec_state", fsm_state, ST_IDLE);
        btn_deb = 3'b000;
        tick();

        // centre together with dec only centres
        btn_deb = 3'b110;
        tick();
        check("ctr_dec_pulse", pulse_us, 1500);
        check("ctr_dec_stb", step_stb, 1);
        check("ctr_dec_state", fsm_state, ST_IDLE);
        btn_deb = 3'b000;
        tick();

`ifdef SERVO_BTN_REPEAT_EN
        // hold inc: steps at +1, +61, then every 24 cycles
        btn_deb = 3'b001;
        stb_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (step_stb) begin
                if (stb_cnt < 7) begin
                    check("hold_step_cycle", i, exp_cyc[stb_cnt]);
                    check("hold_step_pulse", pulse_us, 1510 + 10 * stb_cnt);
                end
                stb_cnt++;
            end
        end
        check("hold_step_count", stb_cnt, 7);
        check("hold_state_repeat", fsm_state, ST_REPEAT);

        // keep holding until 1700, then reset in REPEAT
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (pulse_us == 12'd1700) found = 1;
        end
        check("reach_1700", found, 1);
        check("reach_1700_state", fsm_state, ST_REPEAT);
        rst = 1'b1;
        tick();
        check("rst_rep_pulse", pulse_us, 1500);
        check("rst_rep_state", fsm_state, ST_IDLE);
        check("rst_rep_stb", step_stb, 0);
        // button still held as reset falls -> immediate step
        rst = 1'b0;
        tick();
        check("post_rst_pulse", pulse_us, 1510);
        check("post_rst_stb", step_stb, 1);
        btn_deb = 3'b000;
        tick();

        // opposite button during HOLD aborts with no step
        btn_deb = 3'b001;
        repeat (30) tick();
        check("abort_hold_state", fsm_state, ST_HOLD);
        btn_deb = 3'b011;
        tick();
        check("abort_pulse", pulse_us, 1520);
        check("abort_stb", step_stb, 0);
        check("abort_state", fsm_state, ST_IDLE);
        btn_deb = 3'b000;
        tick();
        tap(3'b100);
        check("recentre", pulse_us, 1500);
`else
        // hold dec: exactly one step
        btn_deb = 3'b010;
        stb_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (step_stb) stb_cnt++;
        end
        check("dec_hold_count", stb_cnt, 1);
        check("dec_hold_pulse", pulse_us, 1490);
        check("dec_hold_state", fsm_state, ST_IDLE);
        btn_deb = 3'b000;
        tick();
        // reset with dec held, then step right after reset
        btn_deb = 3'b010;
        rst = 1'b1;
        tick();
        check("rst_pulse", pulse_us, 1500);
        check("rst_stb", step_stb, 0);
        rst = 1'b0;
        tick();
        check("post_rst_pulse", pulse_us, 1490);
        check("post_rst_stb", step_stb, 1);
        btn_deb = 3'b000;
        tick();
        tap(3'b100);
        check("recentre", pulse_us, 1500);
`endif

        // saturate at PW_MAX with repeated taps
        stb_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            btn_deb = 3'b001;
            tick();
            if (step_stb) stb_cnt++;
            btn_deb = 3'b000;
            tick();
        end
        check("max_strobes", stb_cnt, 100);
        check("max_pulse", pulse_us, 2500);
        check("max_flag", at_max, 1);
        btn_deb = 3'b001;
        tick();
        check("max_press_pulse", pulse_us, 2500);
        check("max_press_stb", step_stb, 0);
`ifdef SERVO_BTN_REPEAT_EN
        check("max_press_state", fsm_state, ST_HOLD);
`endif
        btn_deb = 3'b000;
        tick();

        // saturate at PW_MIN
        stb_cnt = 0;
        for (int i = 0; i < 210; i++) begin
            btn_deb = 3'b010;
            tick();
            if (step_stb) stb_cnt++;
            btn_deb = 3'b000;
            tick();
        end
        check("min_strobes", stb_cnt, 200);
        check("min_pulse", pulse_us, 500);
        check("min_flags", {at_min, at_max}, 2);
        btn_deb = 3'b010;
        tick();
        check("min_press_stb", step_stb, 0);
        btn_deb = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
